// File: rtl/wallace_mac_8x8_pkg.sv
// Shared constants and carry-save helper for the pipelined 8x8 multiply-accumulate stage.
package wallace_mac_8x8_pkg;

   localparam int MUL_W     = 8;
   localparam int PROD_W    = 16;
   localparam int DEF_ACC_W = 24;
   localparam int DEF_LEN_W = 8;

   // One row pair produced by a 3:2 compressor layer of the multiplier tree
   typedef struct packed {
      logic [PROD_W-1:0] sum;
      logic [PROD_W-1:0] carry;
   } csa_t;

   // Bitwise full-adder across three rows; the carry row is already shifted to its weight
   function automatic csa_t csa(input logic [PROD_W-1:0] x,
                                input logic [PROD_W-1:0] y,
                                input logic [PROD_W-1:0] z);
      csa_t r;
      r.sum   = x ^ y ^ z;
      r.carry = ((x & y) | (x & z) | (y & z)) << 1;
      return r;
   endfunction

endpackage

// File: rtl/wallace_mac_8x8_product.sv
// Combinational unsigned 8x8 Wallace-tree multiplier: eight partial-product rows
// reduced to two by four carry-save layers, then one carry-propagate add.
module wallace_8x8_product
   import wallace_mac_8x8_pkg::*;
(
   input  logic [MUL_W-1:0]  a,
   input  logic [MUL_W-1:0]  b,
   output logic [PROD_W-1:0] p
);

   logic [PROD_W-1:0] pp [MUL_W];
   logic [PROD_W-1:0] row;
   csa_t              l1a;
   csa_t              l1b;
   csa_t              l2a;
   csa_t              l2b;
   csa_t              l3;
   csa_t              l4;

   // Generate each partial-product row aligned to its weight
   always_comb begin
      row = '0;
      for (int i = 0; i < MUL_W; i++) begin
         row            = '0;
         row[MUL_W-1:0] = {MUL_W{b[i]}} & a;
         pp[i]          = row << i;
      end
   end

   // Reduce 8 rows -> 6 -> 4 -> 3 -> 2; the product always fits in 16 bits so no carry is lost
   always_comb begin
      l1a = csa(pp[0], pp[1], pp[2]);
      l1b = csa(pp[3], pp[4], pp[5]);
      l2a = csa(l1a.sum, l1a.carry, l1b.sum);
      l2b = csa(l1b.carry, pp[6], pp[7]);
      l3  = csa(l2a.sum, l2a.carry, l2b.sum);
      l4  = csa(l3.sum, l3.carry, l2b.carry);
      p   = l4.sum + l4.carry;
   end

endmodule

// File: rtl/wallace_mac_8x8.sv
// Three-stage unsigned multiply-accumulate: operand register, product register,
// then a per-vector accumulator whose finished result is held on an output handshake.
module wallace_mac_8x8
   import wallace_mac_8x8_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MUL_W-1:0]   a,
   input  logic [MUL_W-1:0]   b,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   acc,
   output logic [LEN_W-1:0]   count,
   output logic               overflow
);

   logic              stall;

   logic              v1;
   logic              last1;
   logic [MUL_W-1:0]  a1;
   logic [MUL_W-1:0]  b1;
   logic [PROD_W-1:0] prod;

   logic              v2;
   logic              last2;
   logic [PROD_W-1:0] p2;

   logic [ACC_W-1:0]  sum;
   logic [LEN_W-1:0]  cnt;
   logic              ovf;

   logic [ACC_W:0]    wide_sum;
   logic [ACC_W-1:0]  nsum;
   logic              ncarry;
   logic [LEN_W-1:0]  ncnt;

   // A result waiting on the consumer freezes the whole pipeline
   always_comb begin
      stall    = out_valid && !out_ready;
      in_ready = !stall;
   end

   // Next accumulator value, its carry out, and the saturating beat count
   always_comb begin
      wide_sum = (ACC_W+1)'(sum) + (ACC_W+1)'(p2);
      nsum     = wide_sum[ACC_W-1:0];
      ncarry   = wide_sum[ACC_W];
      ncnt     = (cnt == '1) ? cnt : cnt + LEN_W'(1);
   end

   // Stage 1: capture the accepted operand pair in front of the multiplier
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v1    <= 1'b0;
         last1 <= 1'b0;
         a1    <= '0;
         b1    <= '0;
      end else if (!stall) begin
         v1 <= in_valid;
         if (in_valid) begin
            a1    <= a;
            b1    <= b;
            last1 <= in_last;
         end
      end
   end

   wallace_8x8_product u_product (
      .a (a1),
      .b (b1),
      .p (prod)
   );

   // Stage 2: register the product so the array never reaches the accumulator combinationally
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v2    <= 1'b0;
         last2 <= 1'b0;
         p2    <= '0;
      end else if (!stall) begin
         v2 <= v1;
         if (v1) begin
            p2    <= prod;
            last2 <= last1;
         end
      end
   end

   // Stage 3: running sum of the current vector, cleared when its last beat completes
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sum <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (!stall && v2) begin
         if (last2) begin
            sum <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end else begin
            sum <= nsum;
            cnt <= ncnt;
            ovf <= ovf | ncarry;
         end
      end
   end

   // Output register: load a finished vector, else drop the result once it has been taken
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         out_valid <= 1'b0;
         acc       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else if (!stall) begin
         if (v2 && last2) begin
            out_valid <= 1'b1;
            acc       <= nsum;
            count     <= ncnt;
            overflow  <= ovf | ncarry;
         end else if (out_valid) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wallace_mac_8x8.sv
// Directed and random checks of the multiply-accumulate stage against a sum-per-vector model.
module tb_wallace_mac_8x8;

   logic        clk;
   logic        clrn;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] acc;
   logic [7:0]  count;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int results_seen = 0;

   typedef struct {
      logic [23:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } result_t;

   result_t expq[$];
   longint  run_sum = 0;
   int      run_cnt = 0;

   wallace_mac_8x8 dut (
      .clk       (clk),
      .clrn      (clrn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .count     (count),
      .overflow  (overflow)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one beat and hold it until the stage accepts it
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vl);
      logic took;
      took     = 1'b0;
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      in_last  = vl;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         if (took) break;
      end
      if (!took) checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for a result, check it at the negedge, then step past its hand-off edge
   task automatic expectResult(input string tag, input logic [23:0] eacc, input logic [7:0] ecnt, input logic eovf);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
      checkOutput({tag, "_acc"}, 32'(acc), 32'(eacc));
      checkOutput({tag, "_count"}, 32'(count), 32'(ecnt));
      checkOutput({tag, "_ovf"}, 32'(overflow), 32'(eovf));
      @(posedge clk);
      #1;
   endtask

   // Reference model: integer sum per vector, queued on the last beat, compared when taken
   always @(negedge clk) begin
      if (!clrn) begin
         expq.delete();
         run_sum = 0;
         run_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            results_seen++;
            if (expq.size() == 0) begin
               checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
               result_t e;
               e = expq.pop_front();
               checkOutput("model_acc", 32'(acc), 32'(e.acc));
               checkOutput("model_count", 32'(count), 32'(e.cnt));
               checkOutput("model_ovf", 32'(overflow), 32'(e.ovf));
            end
         end
         if (in_valid && in_ready) begin
            run_sum += longint'(a) * longint'(b);
            run_cnt++;
            if (in_last) begin
               result_t r;
               r.acc = run_sum[23:0];
               r.cnt = (run_cnt > 255) ? 8'hFF : 8'(run_cnt);
               r.ovf = (run_sum >= (64'd1 << 24));
               expq.push_back(r);
               run_sum = 0;
               run_cnt = 0;
            end
         end
      end
   end

   // Directed steps followed by a random stream
   initial begin
      clrn      = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clrn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_acc", 32'(acc), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // Single beat ff*ff with exact two-edge latency
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("lat_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(out_valid), 32'd1);
      checkOutput("lat_acc", 32'(acc), 32'h00FE01);
      checkOutput("lat_count", 32'(count), 32'd1);
      checkOutput("lat_ovf", 32'(overflow), 32'd0);
      @(posedge clk);
      #1;

      // Four-beat vector followed immediately by a one-beat vector
      applyStimulus(8'h01, 8'h01, 1'b0);
      applyStimulus(8'h01, 8'h02, 1'b0);
      applyStimulus(8'h01, 8'h03, 1'b0);
      applyStimulus(8'h01, 8'h04, 1'b1);
      applyStimulus(8'h00, 8'h01, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("vec4_valid", 32'(out_valid), 32'd1);
      checkOutput("vec4_acc", 32'(acc), 32'h00000A);
      checkOutput("vec4_count", 32'(count), 32'd4);
      @(posedge clk);
      #1;
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_acc", 32'(acc), 32'd0);
      checkOutput("b2b_count", 32'(count), 32'd1);
      @(posedge clk);
      #1;

      // Consumer stall with a pending pair presented throughout
      out_ready = 1'b0;
      applyStimulus(8'h05, 8'h05, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 8'h03;
      b        = 8'h02;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_acc", 32'(acc), 32'h000019);
         checkOutput("hold_count", 32'(count), 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      applyStimulus(8'h03, 8'h02, 1'b0);
      applyStimulus(8'h04, 8'h03, 1'b1);
      expectResult("after_hold", 24'h000012, 8'd2, 1'b0);

      // Long vector: wraps the accumulator and saturates the count
      for (int i = 0; i < 259; i++) applyStimulus(8'hFF, 8'hFF, (i == 258));
      expectResult("long", 24'h00FB03, 8'hFF, 1'b1);
      applyStimulus(8'h02, 8'h01, 1'b1);
      expectResult("after_long", 24'h000002, 8'd1, 1'b0);

      // Reset with a result pending and two beats in flight
      out_ready = 1'b0;
      applyStimulus(8'h01, 8'h01, 1'b1);
      applyStimulus(8'h02, 8'h02, 1'b0);
      applyStimulus(8'h03, 8'h03, 1'b0);
      checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
      clrn = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_acc", 32'(acc), 32'd0);
      checkOutput("async_rst_count", 32'(count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      clrn      = 1'b1;
      out_ready = 1'b1;
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(8'h02, 8'h03, 1'b1);
      expectResult("post_rst", 24'h000006, 8'd1, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Random stream with random backpressure; the model checks every taken result
      results_seen = 0;
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = 8'($urandom);
         b         = 8'($urandom);
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      applyStimulus(8'($urandom), 8'($urandom), 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("drain_queue", 32'(expq.size()), 32'd0);
      checkOutput("drain_valid", 32'(out_valid), 32'd0);
      checkOutput("random_results_seen", 32'(results_seen >= 20), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wallace_mac_8x8.md
# wallace_mac_8x8

Pipelined unsigned multiply-accumulate stage built around the combinational `wallace_8x8_product` array. It accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers the operands in front of the multiplier. It registers the 16-bit product after the multiplier and accumulates the products of one vector, delimited by `in_last`, into a wide sum. The finished sum, beat count and overflow flag are presented on a held output handshake, so the multiplier feeds sequential consumers (dot-product, FIR tap) without combinational paths through the array.

## Interface
- `ACC_W`, default 24: accumulator and result width; must be ≥ 16.
- `LEN_W`, default 8: beat-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: stage can accept a pair.
- `a` in 8: unsigned multiplicand.
- `b` in 8: unsigned multiplier.
- `in_last` in 1: this pair ends the current vector.
- `out_valid` out 1: result valid, held until taken.
- `out_ready` in 1: consumer takes the result.
- `acc` out ACC_W: vector sum, modulo 2^ACC_W.
- `count` out LEN_W: beats in the vector, saturating at all-ones.
- `overflow` out 1: carry out of the accumulator occurred in this vector.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Pipeline stages:
  - S1: registers `a`, `b`, `last` and valid `v1`.
  - S2: registers `p = a*b` (16 bits) from `wallace_8x8_product`, with `last` and `v2`.
  - S3: running sum `sum`, running count `cnt`, sticky `ovf`.
- `stall = out_valid && !out_ready`.
  - While stalled, every stage register, `sum`, `cnt` and the output registers hold.
  - `in_ready = !stall` (combinational from `out_ready`).
- When `v2` is set and not stalled:
  - `nsum = sum + zero-extend(p)`.
  - `ncarry` = carry out of that add.
  - `ncnt = cnt + 1`, saturating.
- If the S2 beat is not last: `sum <= nsum`, `cnt <= ncnt`, `ovf <= ovf | ncarry`.
- If the S2 beat is last:
  - `acc <= nsum`, `count <= ncnt`, `overflow <= ovf | ncarry`, `out_valid <= 1`.
  - `sum`, `cnt` and `ovf` clear to 0, ready for the next vector.
- `out_valid` clears on `out_valid && out_ready` unless a new last beat completes in the same cycle; in that case the output reloads and `out_valid` stays 1.
- Back-to-back vectors, including one-beat vectors on consecutive cycles, are legal without bubbles while `out_ready = 1`.
- All arithmetic is unsigned. No truncation is applied to `p`.

## Timing
- Reset (`clrn` low, asynchronous) clears all registers:
  - `out_valid = 0`, `acc = 0`, `count = 0`, `overflow = 0`.
  - All stage valids and `sum`, `cnt`, `ovf` = 0.
  - `in_ready = 1` as soon as reset releases.
- Reset mid-vector or mid-stall discards all in-flight beats and any pending result.
- Latency: a last beat accepted at edge k produces `out_valid = 1` after edge k+2 (no stall).
- Throughput: one beat per cycle while not stalled.
- `acc`, `count` and `overflow` are stable while `out_valid && !out_ready`.
- `in_last` is sampled only on accepted beats. Pairs presented with `in_ready = 0` are neither consumed nor counted.

## Structure
- Shared package holds `MUL_W = 8`, `PROD_W = 16`, and default `ACC_W` and `LEN_W`.
- One sub-module: the existing `wallace_8x8_product`, instantiated unchanged between S1 and S2.
- Pipeline control (stall, valids) and the accumulator live in this module.

## Test plan
- Reset, then a single beat `a=ff`, `b=ff`, last → after 2 cycles `acc=0x00FE01`, `count=1`, `overflow=0`.
- Vector (01,01)(01,02)(01,03)(01,04), last on 4th beat → `acc=0x00000A`, `count=4`. Immediately follow with (00,01) last → `acc=0`, `count=1`, with no bubble.
- Hold `out_ready=0` for 5 cycles after a result, with `in_valid=1` throughout:
  - `in_ready=0` for the whole hold; the result stays constant.
  - After release, the next vector (03,02)(04,03) yields `acc=0x12` (decimal 18).
- 259 beats of (ff,ff), last on the 259th → `acc=0x00FB03`, `overflow=1`, `count=0xFF` (saturated). The next vector (02,01) reports `overflow=0`.
- Pull `clrn` low while 2 beats are in flight and a result is pending:
  - Outputs go to 0 immediately.
  - After release, (02,03) last → `acc=6`, `count=1`.
- Random stream with random `in_valid`/`out_ready` against a reference model → every result matches, and no beats are lost or duplicated.
